// File: rtl/da_lut_gen.sv
// Partial-sum LUT generator for a TAPS-tap distributed-arithmetic FIR.
// Loads TAPS signed coefficients, then writes all 2**TAPS saturated partial sums in ascending address order.
module da_lut_gen #(
   parameter int TAPS = 6,
   parameter int CW   = 6,
   parameter int AW   = 9
) (
   input  logic            clk_80,
   input  logic            rst_80,
   input  logic [CW-1:0]   coef_in_80,
   input  logic            coef_valid_80,
   output logic            coef_ready_80,
   output logic            lut_we_80,
   output logic [TAPS-1:0] lut_addr_80,
   output logic [CW-1:0]   lut_data_80,
   output logic            busy_80,
   output logic            done_80
);

   localparam int IW = $clog2(TAPS);
   localparam logic signed [AW-1:0] SMAX = AW'((1 << (CW-1)) - 1);
   localparam logic signed [AW-1:0] SMIN = AW'(-(1 << (CW-1)));

   typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;

   state_t                 state;
   logic [IW-1:0]          cnt;
   logic [IW-1:0]          tap_idx;
   logic [TAPS-1:0]        addr;
   logic signed [AW-1:0]   acc;
   logic signed [AW-1:0]   acc_next;
   logic [CW-1:0]          h_sel;
   logic [CW-1:0]          h [TAPS];

   function automatic logic [CW-1:0] sat(input logic signed [AW-1:0] v);
      if (v > SMAX)      return SMAX[CW-1:0];
      else if (v < SMIN) return SMIN[CW-1:0];
      else               return v[CW-1:0];
   endfunction

   always_comb begin
      h_sel    = h[tap_idx];
      acc_next = acc;
      if (addr[tap_idx])
         acc_next = acc + {{(AW-CW){h_sel[CW-1]}}, h_sel};
   end

   // lut_data/lut_addr are captured on entry to WRITE so they hold between writes
   always_ff @(posedge clk_80 or posedge rst_80) begin
      if (rst_80) begin
         state         <= IDLE;
         cnt           <= '0;
         tap_idx       <= '0;
         addr          <= '0;
         acc           <= '0;
         coef_ready_80 <= 1'b0;
         lut_addr_80   <= '0;
         lut_data_80   <= '0;
         for (int unsigned i = 0; i < TAPS; i++) h[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               coef_ready_80 <= 1'b1;
               if (coef_valid_80 && coef_ready_80) begin
                  h[cnt] <= coef_in_80;
                  if (cnt == IW'(TAPS-1)) begin
                     cnt           <= '0;
                     addr          <= '0;
                     tap_idx       <= '0;
                     acc           <= '0;
                     coef_ready_80 <= 1'b0;
                     state         <= ACCUM;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            ACCUM: begin
               acc <= acc_next;
               if (tap_idx == IW'(TAPS-1)) begin
                  lut_addr_80 <= addr;
                  lut_data_80 <= sat(acc_next);
                  state       <= WRITE;
               end else begin
                  tap_idx <= tap_idx + 1'b1;
               end
            end
            WRITE: begin
               acc     <= '0;
               tap_idx <= '0;
               if (addr == '1) begin
                  state <= DONE;
               end else begin
                  addr  <= addr + 1'b1;
                  state <= ACCUM;
               end
            end
            DONE: begin
               coef_ready_80 <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign lut_we_80 = (state == WRITE);
   assign busy_80   = (state != IDLE);
   assign done_80   = (state == DONE);

endmodule

// File: tb/tb_da_lut_gen.sv
// Randomized self-checking bench for da_lut_gen against a plain arithmetic partial-sum model.
module tb_da_lut_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] coef;
   logic       valid;
   logic       ready;
   logic       lut_we;
   logic [5:0] lut_addr;
   logic [5:0] lut_data;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;
   int hm [6];

   da_lut_gen #(.TAPS(6), .CW(6), .AW(9)) dut (
      .clk_80        (clk),
      .rst_80        (rst),
      .coef_in_80    (coef),
      .coef_valid_80 (valid),
      .coef_ready_80 (ready),
      .lut_we_80     (lut_we),
      .lut_addr_80   (lut_addr),
      .lut_data_80   (lut_data),
      .busy_80       (busy),
      .done_80       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int model(input int a);
      int s = 0;
      for (int k = 0; k < 6; k++)
         if (((a >> k) & 1) == 1) s += hm[k];
      if (s > 31) s = 31;
      if (s < -32) s = -32;
      return s;
   endfunction

   // one coefficient per negedge; gapmask[i] inserts an idle beat before coefficient i
   task automatic load(input logic [5:0] gapmask);
      for (int i = 0; i < 6; i++) begin
         if (gapmask[i]) begin
            @(negedge clk);
            check("ready_gap", int'(ready), 1);
            valid = 1'b0;
            coef  = 6'($urandom);
         end
         @(negedge clk);
         check("ready_load", int'(ready), 1);
         valid = 1'b1;
         coef  = 6'(hm[i]);
      end
   endtask

   // cycle c is counted from the edge that accepted the last coefficient
   task automatic run_gen(input bit junk, input int abort_at);
      int a;
      bit we_exp;
      for (int c = 1; c <= 449; c++) begin
         @(negedge clk);
         if (c == 1) begin
            valid = junk;
            coef  = 6'd7;
         end else begin
            valid = 1'b0;
         end
         if (c == abort_at) begin
            rst = 1'b1;
            #1;
            check("rst_we", int'(lut_we), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
            check("rst_ready", int'(ready), 0);
            for (int j = 0; j < 4; j++) begin
               @(negedge clk);
               check("rst_hold_we", int'(lut_we), 0);
            end
            rst = 1'b0;
            @(negedge clk);
            check("post_rst_ready", int'(ready), 1);
            check("post_rst_we", int'(lut_we), 0);
            check("post_rst_busy", int'(busy), 0);
            return;
         end
         check("busy", int'(busy), 1);
         check("ready_busy", int'(ready), 0);
         check("done", int'(done), (c == 449) ? 1 : 0);
         we_exp = (c % 7 == 0) && (c <= 448);
         check("we", int'(lut_we), int'(we_exp));
         if (we_exp) begin
            a = c / 7 - 1;
            check("addr", int'(lut_addr), a);
            check("data", $signed(lut_data), model(a));
         end else if (c > 7) begin
            check("addr_hold", int'(lut_addr), c / 7 - 1);
         end
      end
   endtask

   task automatic set_all(input int v);
      for (int k = 0; k < 6; k++) hm[k] = v;
   endtask

   task automatic set_rand();
      for (int k = 0; k < 6; k++) hm[k] = int'($urandom_range(0, 63)) - 32;
   endtask

   initial begin
      rst   = 1'b1;
      valid = 1'b0;
      coef  = '0;
      repeat (2) @(negedge clk);
      check("reset_ready", int'(ready), 0);
      check("reset_we", int'(lut_we), 0);
      check("reset_addr", int'(lut_addr), 0);
      check("reset_data", int'(lut_data), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      rst = 1'b0;

      set_all(0);                       load(6'b000001); run_gen(1'b0, 0);
      hm = '{1, 2, 4, 8, 16, 0};        load(6'b000000); run_gen(1'b0, 0);
      set_all(31);                      load(6'b000000); run_gen(1'b0, 0);
      set_all(-32);                     load(6'b000000); run_gen(1'b0, 0);
      hm = '{31, -32, 0, 0, 0, 0};      load(6'b000000); run_gen(1'b0, 0);
      hm = '{1, 2, 3, 4, 5, 6};         load(6'b001010); run_gen(1'b1, 0);
      set_rand();                       load(6'b000000); run_gen(1'b0, 100);
      set_all(1);                       load(6'b000000); run_gen(1'b0, 0);
      for (int r = 0; r < 3; r++) begin
         set_rand();
         load(6'($urandom));
         run_gen(1'($urandom), 0);
      end
      @(negedge clk);
      check("final_busy", int'(busy), 0);
      check("final_ready", int'(ready), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/da_lut_gen.md
# da_lut_gen

Sequential generator that fills the 64-entry partial-sum LUT used by the 6-tap distributed-arithmetic FIR. It accepts six signed 6-bit tap coefficients over a valid/ready handshake. It then computes every partial sum Σ(addr[k]·h[k]), saturates each to 6 bits, and writes the entries one per address into the LUT RAM through a write port. It is the write side of the LUT that the DA datapath reads, so coefficients become run-time programmable instead of hard-coded.

## Interface
Parameters:
- TAPS, 6, number of taps; also the LUT address width.
- CW, 6, coefficient and LUT data width (signed two's complement).
- AW, 9, internal accumulator width (signed).

Ports:
- clk_80  in  1  single clock; all state changes on its rising edge.
- rst_80  in  1  reset, asynchronous, active-high.
- coef_in_80  in  CW  coefficient; first accepted is h0 (tap for newest sample x0), last is h5.
- coef_valid_80  in  1  coef_in_80 valid.
- coef_ready_80  out  1  block can accept a coefficient.
- lut_we_80  out  1  LUT write strobe, one cycle per entry.
- lut_addr_80  out  TAPS  LUT write address; bit k selects tap k.
- lut_data_80  out  CW  saturated partial sum for lut_addr_80.
- busy_80  out  1  generation in progress.
- done_80  out  1  one-cycle pulse after the last write.

## Operation
- States: IDLE, ACCUM, WRITE, DONE.
- IDLE:
  - coef_ready_80 = 1.
  - On coef_valid_80 & coef_ready_80, store coef_in_80 into h[cnt] and increment cnt (0..5).
  - The 6th acceptance moves to ACCUM with addr=0, bit=0, acc=0, cnt=0.
- ACCUM: 6 cycles, bit k = 0..5.
  - If addr[k], acc <= acc + sext(h[k]) in AW bits; otherwise acc holds.
  - After k=5, go to WRITE.
- WRITE: 1 cycle.
  - lut_we_80 = 1, lut_addr_80 = addr, lut_data_80 = sat(acc).
  - On exit: acc <= 0, bit <= 0.
  - If addr == 63, go to DONE; otherwise addr <= addr+1 and go to ACCUM.
- DONE: 1 cycle. done_80 = 1, then go to IDLE.
- Arithmetic:
  - acc range is -192..+186, so 9 bits never overflow.
  - sat(): acc > 31 → 31 (6'b011111); acc < -32 → -32 (6'b100000); else acc[5:0].
- Handshake:
  - coef_ready_80 = 0 in ACCUM, WRITE and DONE.
  - coef_valid_80 in those states is ignored and nothing is stored.
  - Gaps in coef_valid_80 during loading are allowed; cnt holds.
- Address 0 always writes 0.
- Outputs:
  - All outputs are driven from registers or decoded from the registered state; no combinational path from inputs.
  - lut_addr_80 and lut_data_80 hold their last values outside WRITE.
- Reset, at any time including mid-generation:
  - State → IDLE; cnt, addr, bit, acc, h[] cleared.
  - Partially loaded coefficients are discarded.
  - Generation is abandoned and no further writes occur. Entries already written stay in the RAM, which the block does not own.
- Reset values: coef_ready_80=0 while rst_80 is high and 1 after release (IDLE); lut_we_80=0, lut_addr_80=0, lut_data_80=0, busy_80=0, done_80=0.

## Timing
- Cycle 1 is the first cycle after the edge that accepts the 6th coefficient.
- busy_80 = 1 in cycles 1..449 (ACCUM, WRITE, DONE); 0 in IDLE.
- Writes:
  - Entry a is written in cycle 7(a+1): address 0 in cycle 7, address 63 in cycle 448.
  - Exactly 64 writes in ascending address order, each with lut_we_80 high for one cycle.
- done_80 is high in cycle 449.
- IDLE and coef_ready_80=1 from cycle 450, so a new coefficient can be accepted at the end of cycle 450.
- Total: 6 load cycles minimum, plus 449 cycles of generation.
- Loading rate: one coefficient per cycle when coef_valid_80 is held high.

## Test plan
- All h=0 → 64 writes of 0, addresses 0..63 at cycles 7,14,..,448; done_80 in cycle 449; busy_80 low in cycle 450.
- h = {1,2,4,8,16,0} → entry a = a mod 32 (addr 31 → 31, addr 63 → 31, addr 32 → 0).
- Saturation:
  - All h=31 → addr 1 → 31, addr 3 → 31, addr 63 → 31.
  - All h=-32 → addr 1 → -32, addr 63 → -32, addr 0 → 0.
  - h = {31,-32,0,0,0,0} → addr 3 → -1.
- Handshake: coef_valid_80 toggles 1,0,1,1,0,1,1,1 carrying values 1..6 on the high cycles → exactly 6 accepted (h0=1..h5=6); the extra valid beat during busy is ignored; addr 63 → 21.
- Reset mid-run: assert rst_80 in cycle 100 (between edges) → lut_we_80, busy_80 and done_80 drop immediately, and no further writes occur. After release, ready=1; a fresh load of all h=1 gives addr 63 → 6 and addr 5 → 2.
- Back-to-back: a second coefficient set is offered from cycle 450 → accepted, and a full second 64-write sequence reflects the new values only.
